wb_write_scheduler: RTL and testbench



---
 rtl/wb_write_scheduler_pkg.sv | 12 +
 rtl/wb_write_scheduler_fifo.sv | 47 ++++
 rtl/wb_write_scheduler.sv | 93 +++++++++
 tb/tb_wb_write_scheduler.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/wb_write_scheduler_pkg.sv
// wb_write_scheduler_pkg: shared widths, writeback entry type and counter-width helper
package wb_write_scheduler_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/wb_write_scheduler_fifo.sv
// wb_fifo: circular buffer with two ordered push ports, one pop port and exposed entries
module wb_fifo
  import wb_write_scheduler_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push0_en,
  input  wb_entry_t       push0,
  input  logic            push1_en,
  input  wb_entry_t       push1,
  input  logic            pop,
  output wb_entry_t       head_entry,
  output logic [PW-1:0]   head,
  output logic [CW-1:0]   count,
  output wb_entry_t       entries [DEPTH],
  output logic [DEPTH-1:0] valid
);
  wb_entry_t mem [DEPTH];
  logic [PW-1:0] tail;
  assign entries = mem;
  assign head_entry = mem[head];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(push0_en) + PW'(push1_en);
      count <= count + CW'(push0_en) + CW'(push1_en) - CW'(pop);
    end
  end
  // push0 lands first so it is older than push1
  always_ff @(posedge clk) begin
    if (push0_en) mem[tail] <= push0;
    if (push1_en) mem[push0_en ? tail + PW'(1) : tail] <= push1;
  end
  // an entry is live when its distance from head is below count
  always_comb begin
    for (int i = 0; i < DEPTH; i++) valid[i] = {1'b0, PW'(i) - head} < count;
  end
endmodule

// File: rtl/wb_write_scheduler.sv
// wb_write_scheduler: queues ALU/LSU writebacks in order, one register-file write per cycle; WB_FWD_EN adds forwarding lookup
module wb_write_scheduler #(
  parameter int XLEN = wb_write_scheduler_pkg::XLEN,
  parameter int DEPTH = 4,
  localparam int CW = wb_write_scheduler_pkg::cnt_w(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            rf_regWrite,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_writeData,
  input  logic [4:0]      q_rs1,
  input  logic [4:0]      q_rs2,
  output logic            fwd1_hit,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd1_data,
  output logic [XLEN-1:0] fwd2_data,
  output logic [CW-1:0]   count,
  output logic            wb_idle
);
  import wb_write_scheduler_pkg::*;
  localparam int PW = $clog2(DEPTH);
  wb_entry_t head_entry;
  wb_entry_t entries [DEPTH];
  logic [DEPTH-1:0] fvalid;
  logic [PW-1:0] fhead;
  logic pop;
  assign lsu_ready = count < CW'(DEPTH);
  assign alu_ready = lsu_valid ? count < CW'(DEPTH - 1) : lsu_ready;
  assign pop = count != '0;
  assign wb_idle = !pop && !rf_regWrite;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push0_en  (lsu_valid && lsu_ready && lsu_rd != '0),
    .push0     ({lsu_rd, lsu_data}),
    .push1_en  (alu_valid && alu_ready && alu_rd != '0),
    .push1     ({alu_rd, alu_data}),
    .pop       (pop),
    .head_entry(head_entry),
    .head      (fhead),
    .count     (count),
    .entries   (entries),
    .valid     (fvalid)
  );
  // output register drains the queue head every cycle it is non-empty
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_regWrite  <= 1'b0;
      rf_rd        <= '0;
      rf_writeData <= '0;
    end else begin
      rf_regWrite <= pop;
      if (pop) begin
        rf_rd        <= head_entry.rd;
        rf_writeData <= head_entry.data;
      end
    end
  end
`ifdef WB_FWD_EN
  function automatic logic [XLEN:0] lookup(input logic [4:0] q);
    lookup = (rf_regWrite && rf_rd == q) ? {1'b1, rf_writeData} : '0;
    for (int k = 0; k < DEPTH; k++)
      if (fvalid[fhead + PW'(k)] && entries[fhead + PW'(k)].rd == q)
        lookup = {1'b1, entries[fhead + PW'(k)].data};
    if (q == '0) lookup = '0;
  endfunction
  // scan oldest to youngest so the youngest match wins
  always_comb begin
    {fwd1_hit, fwd1_data} = lookup(q_rs1);
    {fwd2_hit, fwd2_data} = lookup(q_rs2);
  end
`else
  logic unused_fwd;
  assign fwd1_hit = 1'b0;
  assign fwd2_hit = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
  // fold otherwise-dangling lookup inputs into a single sink
  always_comb begin
    unused_fwd = ^{q_rs1, q_rs2, fvalid, fhead};
    for (int i = 0; i < DEPTH; i++) unused_fwd = unused_fwd ^ (^entries[i]);
  end
`endif
endmodule

// File: tb/tb_wb_write_scheduler.sv
// tb_wb_write_scheduler: scoreboard bench for wb_write_scheduler
module tb_wb_write_scheduler;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic lsu_valid, lsu_ready, alu_valid, alu_ready, rf_regWrite;
  logic [4:0] lsu_rd, alu_rd, rf_rd, q_rs1, q_rs2;
  logic [XLEN-1:0] lsu_data, alu_data, rf_writeData, fwd1_data, fwd2_data;
  logic fwd1_hit, fwd2_hit, wb_idle;
  logic [2:0] count;
  int tests = 0;
  int fails = 0;
  logic [36:0] sb [$];

  wb_write_scheduler #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .rf_regWrite(rf_regWrite), .rf_rd(rf_rd), .rf_writeData(rf_writeData),
    .q_rs1(q_rs1), .q_rs2(q_rs2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .count(count), .wb_idle(wb_idle)
  );

  always #5 clk = ~clk;

  task automatic step(input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic av, input logic [4:0] ard, input logic [31:0] ad);
    int n;
    logic el, ea, pop_now;
    logic [36:0] e;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    #1;
    n = sb.size();
    el = n < DEPTH;
    ea = lv ? (n <= DEPTH - 2) : el;
    tests++;
    if (lsu_ready !== el) begin fails++; $display("FAIL lsu_ready: got %b expected %b", lsu_ready, el); end
    tests++;
    if (alu_ready !== ea) begin fails++; $display("FAIL alu_ready: got %b expected %b", alu_ready, ea); end
    pop_now = n != 0;
    e = '0;
    if (pop_now) e = sb.pop_front();
    if (lv && el && lrd != 0) sb.push_back({lrd, ld});
    if (av && ea && ard != 0) sb.push_back({ard, ad});
    @(posedge clk);
    #1;
    tests++;
    if (rf_regWrite !== pop_now) begin fails++; $display("FAIL rf_regWrite: got %b expected %b", rf_regWrite, pop_now); end
    if (pop_now) begin
      tests++;
      if ({rf_rd, rf_writeData} !== e)
        begin fails++; $display("FAIL rf_write: got rd=%0d data=%h expected rd=%0d data=%h", rf_rd, rf_writeData, e[36:32], e[31:0]); end
    end
    tests++;
    if (count !== 3'(sb.size())) begin fails++; $display("FAIL count: got %0d expected %0d", count, sb.size()); end
    tests++;
    if (wb_idle !== (sb.size() == 0 && !pop_now)) begin fails++; $display("FAIL wb_idle: got %b expected %b", wb_idle, sb.size() == 0 && !pop_now); end
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    lsu_valid = 1'b0; alu_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    tests++;
    if ({rf_regWrite, rf_rd, rf_writeData} !== '0)
      begin fails++; $display("FAIL reset_rf: got we=%b rd=%0d data=%h expected zeros", rf_regWrite, rf_rd, rf_writeData); end
    tests++;
    if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
    tests++;
    if (wb_idle !== 1'b1) begin fails++; $display("FAIL reset_idle: got %b expected 1", wb_idle); end
  endtask

  task automatic test_single();
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    idle();
    idle();
  endtask

  task automatic test_same_edge();
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    repeat (3) idle();
  endtask

  task automatic test_full();
    for (int i = 0; i < 6; i++) step(1'b1, 5'(i + 1), 32'h100 + i, 1'b1, 5'(i + 9), 32'h200 + i);
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 20), 32'h300 + i);
    repeat (5) idle();
  endtask

  task automatic test_rd0();
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    step(1'b1, 5'd0, 32'h66, 1'b1, 5'd0, 32'h77);
    idle();
  endtask

  task automatic test_fwd();
    logic eh;
    step(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
    for (int p = 0; p < 4; p++) begin
      if (p > 0) idle();
      q_rs1 = 5'd7;
      q_rs2 = (p == 0) ? 5'd0 : 5'd9;
      #1;
      eh = FWD && p < 3;
      tests++;
      if (fwd1_hit !== eh) begin fails++; $display("FAIL fwd1_hit[%0d]: got %b expected %b", p, fwd1_hit, eh); end
      tests++;
      if (fwd1_data !== (eh ? 32'hB : 32'h0)) begin fails++; $display("FAIL fwd1_data[%0d]: got %h expected %h", p, fwd1_data, eh ? 32'hB : 32'h0); end
      tests++;
      if ({fwd2_hit, fwd2_data} !== '0) begin fails++; $display("FAIL fwd2[%0d]: got hit=%b data=%h expected 0", p, fwd2_hit, fwd2_data); end
    end
    q_rs1 = 5'd0;
    q_rs2 = 5'd0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      step(1'($urandom), 5'($urandom_range(0, 7)), $urandom, 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
    repeat (5) idle();
  endtask

  task automatic test_reset_mid();
    step(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hA1);
    step(1'b1, 5'd12, 32'hA2, 1'b1, 5'd13, 32'hA3);
    test_reset();
    repeat (3) idle();
  endtask

  initial begin
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    q_rs1 = '0; q_rs2 = '0;
    test_reset();
    test_single();
    test_same_edge();
    test_full();
    test_rd0();
    test_fwd();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
